// File: rtl/pipe_hazard_pkg.sv
// pipe_hazard_pkg: shared tag, forwarding-select and multi-cycle FSM types
package pipe_hazard_pkg;
    localparam int TAG_RD_W = 8;
    localparam int TAG_RF_W = 2;
    typedef enum logic [TAG_RF_W-1:0] {RF_GP = 2'd0, RF_FP = 2'd1} rf_t;
    typedef enum logic [1:0] {
        FWD_REGFILE     = 2'b00,
        FWD_FROM_EX_MEM = 2'b01,
        FWD_FROM_MEM_WB = 2'b10
    } fwd_sel_t;
    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic [TAG_RF_W-1:0] rd_rf;
        logic                we;
        logic                is_load;
        logic                is_mc;
    } stage_tag_t;
    typedef enum logic {MC_IDLE = 1'b0, MC_BUSY = 1'b1} mc_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_match.sv
// hazard_match: compares one ID source against one shadow stage destination tag
module hazard_match
    import pipe_hazard_pkg::*;
(
    input  logic                valid,
    input  logic                we,
    input  logic [TAG_RD_W-1:0] rd,
    input  logic [TAG_RF_W-1:0] rd_rf,
    input  logic [TAG_RD_W-1:0] rs,
    input  logic [TAG_RF_W-1:0] rs_rf,
    input  logic                use_rs,
    output logic                match
);
    assign match = use_rs && valid && we && rd == rs && rd_rf == rs_rf && !(rs_rf == RF_GP && rs == '0);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall, bubble, flush, freeze and forwarding-select control for the 5-stage pipeline
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_RF     = 2,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [REG_ADDR_W-1:0]     id_rs1,
    input  logic [REG_ADDR_W-1:0]     id_rs2,
    input  logic [$clog2(NUM_RF)-1:0] id_rs1_rf,
    input  logic [$clog2(NUM_RF)-1:0] id_rs2_rf,
    input  logic                      id_use_rs1,
    input  logic                      id_use_rs2,
    input  logic [REG_ADDR_W-1:0]     id_rd,
    input  logic [$clog2(NUM_RF)-1:0] id_rd_rf,
    input  logic                      id_rd_we,
    input  logic                      id_is_load,
    input  logic                      id_is_mc,
    input  logic                      mc_done,
    input  logic                      ex_redirect,
    output logic                      if_stall,
    output logic                      if_id_hold,
    output logic                      if_id_flush,
    output logic                      id_ex_bubble,
    output logic                      pipe_freeze,
    output logic [1:0]                ex_fwd_a_sel,
    output logic [1:0]                ex_fwd_b_sel,
    output logic [2:0]                stage_valid,
    output logic                      mc_error,
    output logic [CNT_W-1:0]          stall_count
);
    localparam int MC_W = $clog2(MC_TIMEOUT + 1);

    stage_tag_t          id_tag, ex_q, mem_q;
    logic                wb_valid;
    mc_state_t           state;
    logic [MC_W-1:0]     mc_cnt;
    fwd_sel_t            fwd_a, fwd_b, sel_a, sel_b;
    logic [TAG_RD_W-1:0] rs [2];
    logic [TAG_RF_W-1:0] rs_rf [2];
    logic                use_rs [2];
    logic [1:0]          m_ex, m_mem;
    logic                freeze, redirect, load_use, bubble, timeout, unused_tag;

    assign id_tag = '{valid: id_valid, rd: TAG_RD_W'(id_rd), rd_rf: TAG_RF_W'(id_rd_rf),
                      we: id_rd_we, is_load: id_is_load, is_mc: id_is_mc};
    assign rs[0]     = TAG_RD_W'(id_rs1);
    assign rs[1]     = TAG_RD_W'(id_rs2);
    assign rs_rf[0]  = TAG_RF_W'(id_rs1_rf);
    assign rs_rf[1]  = TAG_RF_W'(id_rs2_rf);
    assign use_rs[0] = id_valid && id_use_rs1;
    assign use_rs[1] = id_valid && id_use_rs2;

    for (genvar s = 0; s < 2; s++) begin : g_src
        hazard_match u_ex (
            .valid(ex_q.valid), .we(ex_q.we), .rd(ex_q.rd), .rd_rf(ex_q.rd_rf),
            .rs(rs[s]), .rs_rf(rs_rf[s]), .use_rs(use_rs[s]), .match(m_ex[s])
        );
        hazard_match u_mem (
            .valid(mem_q.valid), .we(mem_q.we), .rd(mem_q.rd), .rd_rf(mem_q.rd_rf),
            .rs(rs[s]), .rs_rf(rs_rf[s]), .use_rs(use_rs[s]), .match(m_mem[s])
        );
    end

    assign timeout  = state == MC_BUSY && mc_cnt == MC_W'(MC_TIMEOUT);
    assign freeze   = !reset && !mc_done && (state == MC_IDLE ? ex_q.valid && ex_q.is_mc : !timeout);
    assign redirect = !reset && !freeze && ex_redirect;
    assign load_use = !reset && !freeze && !ex_redirect && ex_q.valid && ex_q.is_load && |m_ex;
    assign bubble   = redirect || load_use;

    always_comb begin
        sel_a = m_ex[0] && !ex_q.is_load ? FWD_FROM_EX_MEM : m_mem[0] ? FWD_FROM_MEM_WB : FWD_REGFILE;
        sel_b = m_ex[1] && !ex_q.is_load ? FWD_FROM_EX_MEM : m_mem[1] ? FWD_FROM_MEM_WB : FWD_REGFILE;
    end

    assign if_stall     = freeze || load_use;
    assign if_id_hold   = freeze || load_use;
    assign if_id_flush  = redirect;
    assign id_ex_bubble = bubble;
    assign pipe_freeze  = freeze;
    assign ex_fwd_a_sel = fwd_a;
    assign ex_fwd_b_sel = fwd_b;
    assign stage_valid  = {ex_q.valid, mem_q.valid, wb_valid};
    assign unused_tag   = mem_q.is_load ^ mem_q.is_mc;

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_valid    <= 1'b0;
            fwd_a       <= FWD_REGFILE;
            fwd_b       <= FWD_REGFILE;
            state       <= MC_IDLE;
            mc_cnt      <= '0;
            mc_error    <= 1'b0;
            stall_count <= '0;
        end else begin
            if (if_stall && !(&stall_count))
                stall_count <= stall_count + 1'b1;
            if (!freeze) begin
                ex_q     <= bubble ? '0 : id_tag;
                fwd_a    <= bubble ? FWD_REGFILE : sel_a;
                fwd_b    <= bubble ? FWD_REGFILE : sel_b;
                mem_q    <= ex_q;
                wb_valid <= mem_q.valid;
            end
            if (state == MC_IDLE) begin
                mc_cnt <= MC_W'(1);
                if (freeze)
                    state <= MC_BUSY;
            end else if (mc_done || timeout) begin
                state    <= MC_IDLE;
                mc_error <= mc_error || (timeout && !mc_done);
            end else begin
                mc_cnt <= mc_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors plus a per-cycle behavioural model of the hazard controller
module tb_pipe_hazard_ctrl;
    localparam int CW = 6;
    localparam int TO = 64;

    logic clock = 1'b0, reset = 1'b1;
    logic id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0, id_rd_we = 0, id_is_load = 0, id_is_mc = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
    logic id_rs1_rf = 0, id_rs2_rf = 0, id_rd_rf = 0;
    logic mc_done = 0, ex_redirect = 0;
    logic if_stall, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze, mc_error;
    logic [1:0] ex_fwd_a_sel, ex_fwd_b_sel;
    logic [2:0] stage_valid;
    logic [CW-1:0] stall_count;

    int vecs = 0, errs = 0;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .NUM_RF(2), .MC_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_rf(id_rs1_rf), .id_rs2_rf(id_rs2_rf),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_rd_rf(id_rd_rf), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .id_is_mc(id_is_mc), .mc_done(mc_done), .ex_redirect(ex_redirect),
        .if_stall(if_stall), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze),
        .ex_fwd_a_sel(ex_fwd_a_sel), .ex_fwd_b_sel(ex_fwd_b_sel),
        .stage_valid(stage_valid), .mc_error(mc_error), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {bit v; int rd; int rf; bit we; bit ld; bit mc;} ins_t;

    ins_t mex, mmem;
    bit   mwb, merr;
    int   mfa, mfb, mbusy, mcnt;

    function automatic bit hit(ins_t s, int rs, int rf, bit u);
        return u && s.v && s.we && s.rd == rs && s.rf == rf && !(rf == 0 && rs == 0);
    endfunction

    function automatic int fsel(ins_t e, ins_t m, int rs, int rf, bit u);
        if (hit(e, rs, rf, u) && !e.ld) return 1;
        if (hit(m, rs, rf, u)) return 2;
        return 0;
    endfunction

    // Model: state below is what the pipeline holds now; inputs are stable from negedge to the next posedge
    always @(negedge clock) begin : model
        ins_t idr;
        bit u1, u2, frz, rdr, lu;
        int na, nb;
        u1  = id_valid && id_use_rs1;
        u2  = id_valid && id_use_rs2;
        idr = '{v: id_valid, rd: int'(id_rd), rf: int'(id_rd_rf), we: id_rd_we, ld: id_is_load, mc: id_is_mc};
        frz = !reset && mex.v && mex.mc && !mc_done && mbusy < TO;
        rdr = !reset && !frz && ex_redirect;
        lu  = !reset && !frz && !ex_redirect && mex.v && mex.ld &&
              (hit(mex, int'(id_rs1), int'(id_rs1_rf), u1) || hit(mex, int'(id_rs2), int'(id_rs2_rf), u2));
        chk("if_stall", if_stall, frz || lu);
        chk("if_id_hold", if_id_hold, frz || lu);
        chk("if_id_flush", if_id_flush, rdr);
        chk("id_ex_bubble", id_ex_bubble, rdr || lu);
        chk("pipe_freeze", pipe_freeze, frz);
        chk("ex_fwd_a_sel", ex_fwd_a_sel, mfa);
        chk("ex_fwd_b_sel", ex_fwd_b_sel, mfb);
        chk("stage_valid", stage_valid, {mex.v, mmem.v, mwb});
        chk("mc_error", mc_error, merr);
        chk("stall_count", stall_count, mcnt);
        if (reset) begin
            mex = '{default: 0}; mmem = '{default: 0};
            mwb = 0; merr = 0; mfa = 0; mfb = 0; mbusy = 0; mcnt = 0;
        end else begin
            if ((frz || lu) && mcnt < (1 << CW) - 1) mcnt++;
            if (mex.v && mex.mc && !mc_done && mbusy == TO) merr = 1;
            if (frz) mbusy++;
            else begin
                na    = fsel(mex, mmem, int'(id_rs1), int'(id_rs1_rf), u1);
                nb    = fsel(mex, mmem, int'(id_rs2), int'(id_rs2_rf), u2);
                mbusy = 0;
                mwb   = mmem.v;
                mmem  = mex;
                if (rdr || lu) begin
                    mex = '{default: 0}; mfa = 0; mfb = 0;
                end else begin
                    mex = idr; mfa = na; mfb = nb;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setid(input bit v, input int rd, input int rdf, input bit we, input bit ld, input bit mc,
                         input int r1, input int f1, input bit u1, input int r2, input int f2, input bit u2);
        id_valid = v; id_rd = 5'(rd); id_rd_rf = 1'(rdf); id_rd_we = we; id_is_load = ld; id_is_mc = mc;
        id_rs1 = 5'(r1); id_rs1_rf = 1'(f1); id_use_rs1 = u1;
        id_rs2 = 5'(r2); id_rs2_rf = 1'(f2); id_use_rs2 = u2;
    endtask

    task automatic nop();
        setid(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        nop();
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1; nop(); tick(); reset = 0;
    endtask

    initial begin
        tick(); tick();
        ex_redirect = 1;
        #3;
        chk("rst_flush", if_id_flush, 0);
        chk("rst_bubble", id_ex_bubble, 0);
        chk("rst_count", stall_count, 0);
        ex_redirect = 0; reset = 0;
        tick();
        // load-use: lw r3 then add r4,r3,r5
        setid(1, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        setid(1, 4, 0, 1, 0, 0, 3, 0, 1, 5, 0, 1); #3;
        chk("lu_stall", if_stall, 1);
        chk("lu_bubble", id_ex_bubble, 1);
        chk("lu_hold", if_id_hold, 1);
        tick(); #3;
        chk("lu_stall_once", if_stall, 0);
        chk("lu_count", stall_count, 1);
        tick(); nop(); #3;
        chk("lu_fwd_a", ex_fwd_a_sel, 2'b10);
        chk("lu_fwd_b", ex_fwd_b_sel, 2'b00);
        chk("lu_valid", stage_valid, 3'b101);
        tick(); drain();
        // ALU back-to-back, r0 never forwarded, f0 is
        setid(1, 3, 0, 1, 0, 0, 1, 0, 1, 2, 0, 1); tick();
        setid(1, 6, 0, 1, 0, 0, 1, 0, 1, 3, 0, 1); #3;
        chk("alu_nostall", if_stall, 0);
        tick(); nop(); #3;
        chk("alu_fwd_b", ex_fwd_b_sel, 2'b01);
        chk("alu_fwd_a", ex_fwd_a_sel, 2'b00);
        tick();
        setid(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        setid(1, 6, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1); tick();
        nop(); #3;
        chk("r0_fwd_a", ex_fwd_a_sel, 2'b00);
        chk("r0_fwd_b", ex_fwd_b_sel, 2'b00);
        tick(); drain();
        setid(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        setid(1, 2, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0); tick();
        nop(); #3;
        chk("f0_fwd_a", ex_fwd_a_sel, 2'b01);
        tick(); drain();
        // file separation: FP f3 does not feed GP r3
        setid(1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        setid(1, 8, 0, 1, 0, 0, 3, 0, 1, 0, 0, 0); tick();
        setid(1, 9, 1, 1, 0, 0, 0, 0, 0, 3, 1, 1); #3;
        chk("rf_gp_fwd_a", ex_fwd_a_sel, 2'b00);
        tick(); nop(); #3;
        chk("rf_fp_fwd_b", ex_fwd_b_sel, 2'b10);
        tick(); drain();
        // multi-cycle: 5 freeze cycles then mc_done
        do_reset();
        setid(1, 7, 0, 1, 0, 1, 1, 0, 1, 2, 0, 1); tick();
        setid(1, 12, 0, 1, 0, 0, 7, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            #3; chk("mc_freeze", pipe_freeze, 1); tick();
        end
        mc_done = 1; #3;
        chk("mc_release", pipe_freeze, 0);
        chk("mc_release_stall", if_stall, 0);
        tick(); mc_done = 0; nop(); #3;
        chk("mc_count", stall_count, 5);
        chk("mc_fwd_a", ex_fwd_a_sel, 2'b01);
        tick(); drain();
        setid(1, 13, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0); tick();
        mc_done = 1; nop(); #3;
        chk("mc_1cyc", pipe_freeze, 0);
        tick(); mc_done = 0; #3;
        chk("mc_1cyc_count", stall_count, 5);
        drain();
        // timeout: freeze exactly TO cycles, then sticky error; stall_count saturates at 63
        do_reset();
        setid(1, 7, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0); tick(); nop();
        for (int i = 0; i < TO; i++) begin
            #3; chk("to_freeze", pipe_freeze, 1); tick();
        end
        #3;
        chk("to_release", pipe_freeze, 0);
        chk("to_err_pending", mc_error, 0);
        tick(); #3;
        chk("to_err", mc_error, 1);
        chk("to_sat", stall_count, 63);
        drain(); #3;
        chk("to_err_sticky", mc_error, 1);
        // redirect beats a simultaneous load-use
        setid(1, 9, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        setid(1, 10, 0, 1, 0, 0, 9, 0, 1, 0, 0, 0); ex_redirect = 1; #3;
        chk("rd_flush", if_id_flush, 1);
        chk("rd_bubble", id_ex_bubble, 1);
        chk("rd_nostall", if_stall, 0);
        tick(); ex_redirect = 0;
        setid(1, 11, 0, 1, 0, 0, 10, 0, 1, 0, 0, 0); #3;
        chk("rd_valid", stage_valid, 3'b010);
        chk("rd_nostall2", if_stall, 0);
        tick(); nop(); #3;
        chk("rd_nofwd", ex_fwd_a_sel, 2'b00);
        tick(); drain();
        // reset while BUSY
        setid(1, 7, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0); tick(); nop(); tick(); #3;
        chk("busy_freeze", pipe_freeze, 1);
        reset = 1; tick(); #3;
        chk("rb_freeze", pipe_freeze, 0);
        chk("rb_count", stall_count, 0);
        chk("rb_valid", stage_valid, 0);
        chk("rb_err", mc_error, 0);
        reset = 0; tick(); #3;
        chk("rb_idle", pipe_freeze, 0);
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Centralised, parametrised hazard and stall controller for the 5-stage integer/FP pipeline.
- Replaces the scattered load-stall, multiply-stall and forwarding-select logic with one block.
- Keeps its own shadow of destination tags per stage and generates stall, bubble, flush and forwarding selects.
- Adds register-file-aware hazards (GP/FP), branch/jump squash, multi-cycle-unit freeze with timeout, and a stall counter.

Parameters:
REG_ADDR_W, 5, register index width
NUM_RF, 2, register files distinguished by tag (0=GP, 1=FP); GP index 0 never a hazard
MC_TIMEOUT, 64, max freeze cycles for a multi-cycle op before mc_error sets
CNT_W, 32, stall counter width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_rs1, id_rs2  in  REG_ADDR_W each  source indices
id_rs1_rf, id_rs2_rf  in  $clog2(NUM_RF) each  source file tags
id_use_rs1, id_use_rs2  in  1 each  source actually read
id_rd  in  REG_ADDR_W  destination index
id_rd_rf  in  $clog2(NUM_RF)  destination file
id_rd_we  in  1  instruction writes a register
id_is_load  in  1  memory-to-register instruction
id_is_mc  in  1  multi-cycle (multiply) op
mc_done  in  1  multi-cycle unit result ready (1-cycle pulse)
ex_redirect  in  1  taken branch/jump resolved in EX
if_stall  out  1  hold PC
if_id_hold  out  1  hold IF/ID register
if_id_flush  out  1  squash IF/ID to NOP
id_ex_bubble  out  1  load NOP into ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
ex_fwd_a_sel, ex_fwd_b_sel  out  2 each  registered select for EX: 00 regfile, 01 EX/MEM, 10 MEM/WB
stage_valid  out  3  {EX,MEM,WB} occupancy
mc_error  out  1  sticky timeout flag
stall_count  out  CNT_W  cycles with if_stall=1

Behaviour:
- All outputs 0 at reset; shadow tags invalid; FSM IDLE; reset wins over every input in any state, including mid-freeze.
- Shadow pipeline: per stage {valid, rd, rd_rf, we, is_load}. ID→EX on normal advance; EX→MEM→WB every non-frozen cycle.
- Hazard match: valid & we & rd==rs & rd_rf==rs_rf & use_rs & not(GP and rs==0).
- Load-use: EX stage is_load and it matches either ID source.
  - Response: if_stall=1, if_id_hold=1, id_ex_bubble=1 for exactly 1 cycle.
  - The next cycle forwards from MEM/WB (sel 10).
- Forwarding, computed at ID and registered into ex_fwd_*_sel on advance:
  - Match in EX stage (non-load) → 01.
  - Else match in MEM stage → 10.
  - Else 00; a WB-stage match relies on regfile write-through.
  - The youngest producer wins.
- On bubble, ex_fwd_*_sel register 00.
- Multi-cycle FSM, IDLE/BUSY:
  - IDLE→BUSY when the EX-stage op is mc and not already completed. pipe_freeze, if_stall and if_id_hold are asserted from that cycle.
  - BUSY→IDLE on mc_done. The freeze deasserts in the same cycle as mc_done, so the pipeline advances that edge.
  - A 1-cycle op with mc_done in the start cycle never freezes.
  - A counter increments in BUSY. On reaching MC_TIMEOUT, set mc_error (sticky until reset), force IDLE and release the freeze.
- Redirect, sampled only when pipe_freeze=0:
  - if_id_flush=1 and id_ex_bubble=1 in the same cycle; the ID instruction is not entered into the shadow.
  - Redirect with a simultaneous load-use: the redirect wins and the stall is dropped.
- Priority: reset > freeze > redirect > load-use > normal.
- stall_count increments when if_stall=1. It saturates at all-ones and does not wrap.
- id_valid=0 treated as no sources, no destination.

Decomposition:
- Package pipe_hazard_pkg holds:
  - fwd_sel_t enum (FWD_REGFILE, FWD_FROM_EX_MEM, FWD_FROM_MEM_WB).
  - stage_tag_t struct.
  - mc_state_t enum.
  - Register-file tag constants.
- One sub-module, hazard_match: combinational tag comparator (source vs stage tag), instantiated per source per stage.

Test Plan:
- Load-use: lw r3 in EX, add r4,r3,r5 in ID → 1 cycle of if_stall/id_ex_bubble, then ex_fwd_a_sel=10.
- ALU back-to-back: add r3 in EX, sub r6,r1,r3 in ID → no stall, ex_fwd_b_sel=01. With r0 as destination → 00.
- File separation: FP write f3 in EX, GP read r3 in ID → no hazard, sel 00.
- Multi-cycle: mult in EX, mc_done after 5 cycles → pipe_freeze high exactly 5 cycles, stall_count=5. Without mc_done → mc_error at cycle 64 and freeze released.
- Redirect with load-use in the same cycle → if_id_flush=1, id_ex_bubble=1, no extra stall cycle, the squashed rd not forwarded later.
- Reset asserted in BUSY → all outputs 0 the next cycle, FSM IDLE, stall_count 0.
